mac_clk_rst_seq: RTL and testbench

Per-port reset and clock-enable sequencer for the switch MAC layer. Holds every port MAC in reset until the system is stable, then releases the ports one at a time with a fixed stagger. Generates a per-port single-cycle clock-enable strobe at a runtime-programmable divide ratio, replacing derived clocks. A valid/ready config interface changes a port's divide ratio safely by re-resetting only that port.

---
 rtl/mac_clk_rst_seq_pkg.sv | 21 ++
 rtl/mac_clk_rst_seq_if.sv | 18 +
 rtl/mac_clk_rst_seq_ce_gen.sv | 42 ++++
 rtl/synchronizer.sv | 25 ++
 rtl/mac_clk_rst_seq.sv | 159 +++++++++++++++
 tb/tb_mac_clk_rst_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mac_clk_rst_seq_pkg.sv
// Shared state type, timing defaults and divide-ratio type for the MAC
// port reset / clock-enable sequencer.
package mac_ctrl_pkg;

  localparam int NUM_PORTS      = 4;
  localparam int DIV_W          = 8;
  localparam int DEFAULT_DIV    = 3;
  localparam int SETTLE_CYCLES  = 64;
  localparam int STAGGER_CYCLES = 16;

  typedef logic [DIV_W-1:0] div_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RELEASE,
    RUN,
    RECONF
  } seq_state_e;

endpackage

// File: rtl/mac_clk_rst_seq_if.sv
// Valid/ready configuration channel used to change one port's divide ratio.
interface mac_clk_rst_seq_if #(
  parameter int NUM_PORTS = mac_ctrl_pkg::NUM_PORTS,
  parameter int DIV_W     = mac_ctrl_pkg::DIV_W
);

  // One spare bit above the index width so out-of-range targets are expressible.
  localparam int PORT_W = $clog2(NUM_PORTS) + 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [PORT_W-1:0] cfg_port;
  logic [DIV_W-1:0]  cfg_div;

  modport master (output cfg_valid, output cfg_port, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_port, input cfg_div, output cfg_ready);

endinterface

// File: rtl/mac_clk_rst_seq_ce_gen.sv
// Per-port clock-enable strobe: one pulse every div cycles while the port
// is out of reset, held high for div of 0 or 1.
module mac_port_ce_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_rst_n,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt;
  logic             armed;

  // port_rst_n is the port reset as it will be after this edge, so the strobe
  // drops on the same edge the port re-enters reset; armed delays counting by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
      ce    <= 1'b0;
    end else if (!port_rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
      ce    <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
      ce    <= 1'b0;
    end else if (div <= DIV_W'(1)) begin
      cnt <= '0;
      ce  <= 1'b1;
    end else if (cnt >= div - 1'b1) begin
      cnt <= '0;
      ce  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/synchronizer.sv
// Multi-stage flop synchronizer with asynchronous active-low clear.
module synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mac_clk_rst_seq.sv
// Per-port MAC reset sequencer: settle, staggered release, and per-port
// re-reset when a port's clock-enable divide ratio is reprogrammed.
module mac_clk_rst_seq #(
  parameter int NUM_PORTS      = mac_ctrl_pkg::NUM_PORTS,
  parameter int DIV_W          = mac_ctrl_pkg::DIV_W,
  parameter int DEFAULT_DIV    = mac_ctrl_pkg::DEFAULT_DIV,
  parameter int SETTLE_CYCLES  = mac_ctrl_pkg::SETTLE_CYCLES,
  parameter int STAGGER_CYCLES = mac_ctrl_pkg::STAGGER_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  mac_clk_rst_seq_if.slave     cfg,
  output logic [NUM_PORTS-1:0] port_rst_n,
  output logic [NUM_PORTS-1:0] port_ce,
  output logic                 all_up,
  output logic                 busy
);
  import mac_ctrl_pkg::*;

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int PORT_W = IDX_W + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_PORTS - 1);
  localparam logic [PORT_W-1:0] PORT_LIMIT   = PORT_W'(NUM_PORTS);
  localparam logic [DIV_W-1:0]  DIV_RESET    = DIV_W'(DEFAULT_DIV);

  logic                 rst_sync_n;
  seq_state_e           state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [IDX_W-1:0]     tgt, tgt_next;
  logic [IDX_W-1:0]     cfg_idx;
  logic [NUM_PORTS-1:0] rst_next;
  logic [DIV_W-1:0]     div_q    [NUM_PORTS];
  logic [DIV_W-1:0]     div_next [NUM_PORTS];
  logic                 cfg_ready_q;
  logic                 handshake;
  logic                 cfg_hit;

  synchronizer #(.WIDTH(1), .STAGES(2)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  assign cfg_idx       = cfg.cfg_port[IDX_W-1:0];
  assign handshake     = cfg.cfg_valid && cfg_ready_q;
  assign cfg_hit       = handshake && (cfg.cfg_port < PORT_LIMIT);
  assign cfg.cfg_ready = cfg_ready_q;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    tgt_next   = tgt;
    rst_next   = port_rst_n;
    div_next   = div_q;
    if (cfg_hit) div_next[cfg_idx] = cfg.cfg_div;

    unique case (state)
      IDLE: begin
        if (en) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next  = RELEASE;
          cnt_next    = '0;
          idx_next    = '0;
          rst_next[0] = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == STAGGER_LAST) begin
          cnt_next = '0;
          if (idx == LAST_IDX) begin
            state_next = RUN;
          end else begin
            idx_next           = idx + 1'b1;
            rst_next[idx_next] = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (cfg_hit) begin
          state_next        = RECONF;
          tgt_next          = cfg_idx;
          rst_next[cfg_idx] = 1'b0;
          cnt_next          = '0;
        end
      end
      RECONF: begin
        if (cnt == STAGGER_LAST) begin
          state_next    = RUN;
          rst_next[tgt] = 1'b1;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Dropping enable overrides everything; divide ratios survive.
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      rst_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      tgt         <= '0;
      port_rst_n  <= '0;
      all_up      <= 1'b0;
      busy        <= 1'b0;
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) div_q[i] <= DIV_RESET;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      tgt         <= tgt_next;
      port_rst_n  <= rst_next;
      all_up      <= (state_next == RUN);
      busy        <= state_next inside {SETTLE, RELEASE, RECONF};
      cfg_ready_q <= state_next inside {IDLE, SETTLE, RUN};
      div_q       <= div_next;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ce
    mac_port_ce_gen #(.DIV_W(DIV_W)) u_ce_gen (
      .clk        (clk),
      .rst_n      (rst_sync_n),
      .port_rst_n (rst_next[p]),
      .div        (div_q[p]),
      .ce         (port_ce[p])
    );
  end

endmodule

// File: tb/tb_mac_clk_rst_seq.sv
// Directed bench for mac_clk_rst_seq: startup stagger, strobe spacing,
// reconfiguration, enable drop, out-of-range config and async reset.
module tb_mac_clk_rst_seq;

  localparam int NP = 4;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b0;
  logic [NP-1:0] port_rst_n;
  logic [NP-1:0] port_ce;
  logic          all_up;
  logic          busy;
  logic [2:0]    flags;
  int            checks = 0;
  int            errors = 0;

  mac_clk_rst_seq_if #(.NUM_PORTS(NP), .DIV_W(DW)) cfg_if ();

  mac_clk_rst_seq #(
    .NUM_PORTS(NP), .DIV_W(DW), .DEFAULT_DIV(3), .SETTLE_CYCLES(64), .STAGGER_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg        (cfg_if),
    .port_rst_n (port_rst_n),
    .port_ce    (port_ce),
    .all_up     (all_up),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // {all_up, busy, cfg_ready}: IDLE 001, SETTLE 011, RELEASE/RECONF 010, RUN 101
  assign flags = {all_up, busy, cfg_if.cfg_ready};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [2:0] port, input logic [DW-1:0] div);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_port  = port;
    cfg_if.cfg_div   = div;
    step(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_port  = '0;
    cfg_if.cfg_div   = '0;
    #2 rst_n = 1'b0;
    step(3);
    checks++;
    if ({port_rst_n, port_ce, flags} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", {port_rst_n, port_ce, flags}, 11'b0);
    end
    #3 rst_n = 1'b1;
    step(2);
    checks++;
    if (flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL sync_hold: got %b expected %b", flags, 3'b000);
    end
    step(1);
    checks++;
    if ({port_rst_n, port_ce, flags} !== {8'h00, 3'b001}) begin
      errors++;
      $display("[TB] FAIL idle_after_sync: got %b expected %b", {port_rst_n, port_ce, flags}, {8'h00, 3'b001});
    end
  endtask

  task automatic test_startup();
    logic exp;
    en = 1'b1;
    step(1);
    checks++;
    if ({port_rst_n, flags} !== {4'b0000, 3'b011}) begin
      errors++;
      $display("[TB] FAIL settle_entry: got %b expected %b", {port_rst_n, flags}, {4'b0000, 3'b011});
    end
    step(63);
    checks++;
    if (port_rst_n !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL pre_release: got %b expected %b", port_rst_n, 4'b0000);
    end
    step(1);
    checks++;
    if ({port_rst_n, flags} !== {4'b0001, 3'b010}) begin
      errors++;
      $display("[TB] FAIL release0: got %b expected %b", {port_rst_n, flags}, {4'b0001, 3'b010});
    end
    for (int j = 1; j < 16; j++) begin
      step(1);
      exp = (j % 3 == 0);
      checks++;
      if (port_ce !== {3'b000, exp}) begin
        errors++;
        $display("[TB] FAIL ce0_div3 cycle %0d: got %b expected %b", j, port_ce, {3'b000, exp});
      end
    end
    step(1);
    checks++;
    if (port_rst_n !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL release1: got %b expected %b", port_rst_n, 4'b0011);
    end
    step(16);
    checks++;
    if (port_rst_n !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL release2: got %b expected %b", port_rst_n, 4'b0111);
    end
    step(16);
    checks++;
    if ({port_rst_n, flags} !== {4'b1111, 3'b010}) begin
      errors++;
      $display("[TB] FAIL release3: got %b expected %b", {port_rst_n, flags}, {4'b1111, 3'b010});
    end
    step(15);
    checks++;
    if (all_up !== 1'b0) begin
      errors++;
      $display("[TB] FAIL all_up_early: got %b expected %b", all_up, 1'b0);
    end
    step(1);
    checks++;
    if ({port_rst_n, flags} !== {4'b1111, 3'b101}) begin
      errors++;
      $display("[TB] FAIL run_entry: got %b expected %b", {port_rst_n, flags}, {4'b1111, 3'b101});
    end
  endtask

  task automatic test_reconfig();
    send_cfg(3'd2, 8'd1);
    checks++;
    if ({port_rst_n, port_ce[2], flags} !== {4'b1011, 1'b0, 3'b010}) begin
      errors++;
      $display("[TB] FAIL reconf_entry: got %b expected %b", {port_rst_n, port_ce[2], flags}, {4'b1011, 1'b0, 3'b010});
    end
    step(15);
    checks++;
    if ({port_rst_n, flags} !== {4'b1011, 3'b010}) begin
      errors++;
      $display("[TB] FAIL reconf_hold: got %b expected %b", {port_rst_n, flags}, {4'b1011, 3'b010});
    end
    step(1);
    checks++;
    if ({port_rst_n, port_ce[2], flags} !== {4'b1111, 1'b0, 3'b101}) begin
      errors++;
      $display("[TB] FAIL reconf_exit: got %b expected %b", {port_rst_n, port_ce[2], flags}, {4'b1111, 1'b0, 3'b101});
    end
    for (int j = 0; j < 6; j++) begin
      step(1);
      checks++;
      if (port_ce[2] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ce2_div1 cycle %0d: got %b expected %b", j, port_ce[2], 1'b1);
      end
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    step(1);
    checks++;
    if ({port_rst_n, port_ce, flags} !== {8'h00, 3'b001}) begin
      errors++;
      $display("[TB] FAIL en_drop_run: got %b expected %b", {port_rst_n, port_ce, flags}, {8'h00, 3'b001});
    end
    en = 1'b1;
    step(81);
    checks++;
    if ({port_rst_n, flags} !== {4'b0011, 3'b010}) begin
      errors++;
      $display("[TB] FAIL replay_port1: got %b expected %b", {port_rst_n, flags}, {4'b0011, 3'b010});
    end
    en = 1'b0;
    step(1);
    checks++;
    if ({port_rst_n, port_ce, flags} !== {8'h00, 3'b001}) begin
      errors++;
      $display("[TB] FAIL en_drop_release: got %b expected %b", {port_rst_n, port_ce, flags}, {8'h00, 3'b001});
    end
    en = 1'b1;
    step(64);
    checks++;
    if (port_rst_n !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL replay_pre_release: got %b expected %b", port_rst_n, 4'b0000);
    end
    step(1);
    checks++;
    if (port_rst_n !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL replay_release0: got %b expected %b", port_rst_n, 4'b0001);
    end
    step(32);
    checks++;
    if (port_rst_n !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL replay_release2: got %b expected %b", port_rst_n, 4'b0111);
    end
    for (int j = 0; j < 2; j++) begin
      step(1);
      checks++;
      if (port_ce[2] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL retained_div1 cycle %0d: got %b expected %b", j, port_ce[2], 1'b1);
      end
    end
    step(30);
    checks++;
    if ({port_rst_n, flags} !== {4'b1111, 3'b101}) begin
      errors++;
      $display("[TB] FAIL replay_run: got %b expected %b", {port_rst_n, flags}, {4'b1111, 3'b101});
    end
  endtask

  task automatic test_cfg_settle_ignore();
    logic exp;
    int   pulses;
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    send_cfg(3'd1, 8'd5);
    checks++;
    if ({port_rst_n, flags} !== {4'b0000, 3'b011}) begin
      errors++;
      $display("[TB] FAIL cfg_in_settle: got %b expected %b", {port_rst_n, flags}, {4'b0000, 3'b011});
    end
    step(63);
    checks++;
    if (port_rst_n !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL settle_cfg_release0: got %b expected %b", port_rst_n, 4'b0001);
    end
    step(16);
    checks++;
    if (port_rst_n !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL settle_cfg_release1: got %b expected %b", port_rst_n, 4'b0011);
    end
    for (int j = 1; j < 16; j++) begin
      step(1);
      exp = (j % 5 == 0);
      checks++;
      if (port_ce[1] !== exp) begin
        errors++;
        $display("[TB] FAIL ce1_div5 cycle %0d: got %b expected %b", j, port_ce[1], exp);
      end
    end
    step(33);
    checks++;
    if ({port_rst_n, flags} !== {4'b1111, 3'b101}) begin
      errors++;
      $display("[TB] FAIL settle_cfg_run: got %b expected %b", {port_rst_n, flags}, {4'b1111, 3'b101});
    end
    send_cfg(3'd7, 8'd9);
    checks++;
    if ({port_rst_n, flags} !== {4'b1111, 3'b101}) begin
      errors++;
      $display("[TB] FAIL cfg_out_of_range: got %b expected %b", {port_rst_n, flags}, {4'b1111, 3'b101});
    end
    pulses = 0;
    for (int j = 0; j < 15; j++) begin
      step(1);
      pulses += int'(port_ce[3]);
      checks++;
      if (port_rst_n !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL no_reset_pulse cycle %0d: got %b expected %b", j, port_rst_n, 4'b1111);
      end
    end
    checks++;
    if (pulses !== 5) begin
      errors++;
      $display("[TB] FAIL port3_div_untouched: got %0d pulses expected %0d", pulses, 5);
    end
  endtask

  task automatic test_async_reset();
    logic exp;
    send_cfg(3'd0, 8'd7);
    checks++;
    if ({port_rst_n, flags} !== {4'b1110, 3'b010}) begin
      errors++;
      $display("[TB] FAIL reconf0_entry: got %b expected %b", {port_rst_n, flags}, {4'b1110, 3'b010});
    end
    step(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({port_rst_n, port_ce, flags} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected %b", {port_rst_n, port_ce, flags}, 11'b0);
    end
    step(3);
    checks++;
    if ({port_rst_n, port_ce, flags} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b expected %b", {port_rst_n, port_ce, flags}, 11'b0);
    end
    #3 rst_n = 1'b1;
    step(2);
    checks++;
    if ({port_rst_n, port_ce, flags} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL sync_hold_en: got %b expected %b", {port_rst_n, port_ce, flags}, 11'b0);
    end
    step(1);
    checks++;
    if ({port_rst_n, flags} !== {4'b0000, 3'b011}) begin
      errors++;
      $display("[TB] FAIL post_reset_settle: got %b expected %b", {port_rst_n, flags}, {4'b0000, 3'b011});
    end
    step(64);
    checks++;
    if (port_rst_n !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL post_reset_release0: got %b expected %b", port_rst_n, 4'b0001);
    end
    for (int j = 1; j < 16; j++) begin
      step(1);
      exp = (j % 3 == 0);
      checks++;
      if (port_ce !== {3'b000, exp}) begin
        errors++;
        $display("[TB] FAIL ce0_default_div cycle %0d: got %b expected %b", j, port_ce, {3'b000, exp});
      end
    end
    step(17);
    checks++;
    if (port_rst_n !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL post_reset_release2: got %b expected %b", port_rst_n, 4'b0111);
    end
    step(1);
    checks++;
    if (port_ce[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ce2_default_gap: got %b expected %b", port_ce[2], 1'b0);
    end
    step(2);
    checks++;
    if (port_ce[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ce2_default_pulse: got %b expected %b", port_ce[2], 1'b1);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    test_reset();
    test_startup();
    test_reconfig();
    test_en_drop();
    test_cfg_settle_ignore();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
